// File: rtl/wishbone_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wishbone_reg_arbiter
// Description : Two-master, NUM_SLAVES-slave Wishbone interconnect with
//               round-robin arbitration, byte-address slave decode, a
//               post-ACK release phase that keeps slave STB low, and a bus
//               watchdog raising ERR on decode miss or missing slave ACK.
// Revision    : 1.0 - initial release
// ============================================================================
module wishbone_reg_arbiter #(
    parameter int NUM_SLAVES     = 4,
    parameter int ADDR_WIDTH     = 6,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                      in_clock,
    input  logic                      in_reset,
    input  logic                      in_m0_cyc,
    input  logic                      in_m0_stb,
    input  logic                      in_m0_we,
    input  logic [3:0]                in_m0_sel,
    input  logic [ADDR_WIDTH-1:0]     in_m0_adr,
    input  logic [31:0]               in_m0_dat,
    output logic                      out_m0_ack,
    output logic                      out_m0_err,
    output logic [31:0]               out_m0_dat,
    input  logic                      in_m1_cyc,
    input  logic                      in_m1_stb,
    input  logic                      in_m1_we,
    input  logic [3:0]                in_m1_sel,
    input  logic [ADDR_WIDTH-1:0]     in_m1_adr,
    input  logic [31:0]               in_m1_dat,
    output logic                      out_m1_ack,
    output logic                      out_m1_err,
    output logic [31:0]               out_m1_dat,
    output logic [NUM_SLAVES-1:0]     out_s_cyc,
    output logic [NUM_SLAVES-1:0]     out_s_stb,
    output logic                      out_s_we,
    output logic [3:0]                out_s_sel,
    output logic [31:0]               out_s_dat,
    input  logic [NUM_SLAVES-1:0]     in_s_ack,
    input  logic [32*NUM_SLAVES-1:0]  in_s_dat,
    output logic [1:0]                out_grant
);

    localparam int         c_IDX_W   = ADDR_WIDTH - 2;
    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t               r_state, w_state_next;
    logic [1:0]           r_grant, w_grant_next;       // one-hot {m1, m0}
    logic [c_IDX_W-1:0]   r_index, w_index_next;       // decoded slave index
    logic                 r_last_grant, w_last_grant_next; // 1: m1 served last
    logic [7:0]           r_count, w_count_next;       // BUSY cycles without ACK

    logic                 w_req0, w_req1, w_pick_m1;
    logic                 w_g_cyc, w_g_stb, w_g_we;
    logic [3:0]           w_g_sel;
    logic [31:0]          w_g_dat;
    logic [31:0]          w_index_ext;
    logic                 w_hit;
    logic [NUM_SLAVES-1:0] w_slave_onehot;
    logic                 w_slave_ack;
    logic [31:0]          w_slave_dat;
    logic                 w_ack, w_err;
    logic [31:0]          w_rdat;
    logic                 w_unused_adr_lsbs;

    // Byte-lane bits of the address never take part in slave decode.
    assign w_unused_adr_lsbs = ^{in_m0_adr[1:0], in_m1_adr[1:0]};

    assign w_req0    = in_m0_cyc & in_m0_stb;
    assign w_req1    = in_m1_cyc & in_m1_stb;
    // On a tie the master that was not served last wins.
    assign w_pick_m1 = w_req1 & (~w_req0 | ~r_last_grant);

    // Signals of whichever master currently holds the grant.
    assign w_g_cyc = r_grant[1] ? in_m1_cyc : in_m0_cyc;
    assign w_g_stb = r_grant[1] ? in_m1_stb : in_m0_stb;
    assign w_g_we  = r_grant[1] ? in_m1_we  : in_m0_we;
    assign w_g_sel = r_grant[1] ? in_m1_sel : in_m0_sel;
    assign w_g_dat = r_grant[1] ? in_m1_dat : in_m0_dat;

    assign w_index_ext = 32'(r_index);
    assign w_hit       = (w_index_ext < 32'(NUM_SLAVES));

    // Decode the latched index into a one-hot slave select and pick its ack/data.
    always_comb begin
        w_slave_onehot = '0;
        w_slave_ack    = 1'b0;
        w_slave_dat    = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (w_index_ext == 32'(k)) begin
                w_slave_onehot[k] = 1'b1;
                w_slave_ack       = in_s_ack[k];
                w_slave_dat       = in_s_dat[32*k +: 32];
            end
        end
    end

    // State register and transaction bookkeeping.
    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= 2'b00;
            r_index      <= '0;
            r_last_grant <= 1'b1;
            r_count      <= 8'd0;
        end else begin
            r_state      <= w_state_next;
            r_grant      <= w_grant_next;
            r_index      <= w_index_next;
            r_last_grant <= w_last_grant_next;
            r_count      <= w_count_next;
        end
    end

    // Next-state logic and bus steering.
    always_comb begin
        w_state_next      = r_state;
        w_grant_next      = r_grant;
        w_index_next      = r_index;
        w_last_grant_next = r_last_grant;
        w_count_next      = r_count;
        out_s_cyc         = '0;
        out_s_stb         = '0;
        out_s_we          = 1'b0;
        out_s_sel         = 4'h0;
        out_s_dat         = 32'h0;
        w_ack             = 1'b0;
        w_err             = 1'b0;
        w_rdat            = 32'h0;

        case (r_state)
            ST_IDLE: begin
                if (w_req0 | w_req1) begin
                    w_grant_next = w_pick_m1 ? 2'b10 : 2'b01;
                    w_index_next = w_pick_m1 ? in_m1_adr[ADDR_WIDTH-1:2]
                                             : in_m0_adr[ADDR_WIDTH-1:2];
                    w_count_next = 8'd0;
                    w_state_next = ST_BUSY;
                end
            end

            ST_BUSY: begin
                if (!w_g_cyc) begin
                    // Master abandoned the cycle: drop the slave silently.
                    w_grant_next      = 2'b00;
                    w_last_grant_next = r_grant[1];
                    w_state_next      = ST_IDLE;
                end else if (!w_hit) begin
                    w_err             = 1'b1;
                    w_last_grant_next = r_grant[1];
                    w_state_next      = ST_RELEASE;
                end else begin
                    out_s_cyc = w_slave_onehot;
                    out_s_stb = w_slave_onehot;
                    out_s_we  = w_g_we;
                    out_s_sel = w_g_sel;
                    out_s_dat = w_g_dat;
                    if (w_slave_ack) begin
                        w_ack             = 1'b1;
                        w_rdat            = w_g_we ? 32'h0 : w_slave_dat;
                        w_last_grant_next = r_grant[1];
                        w_state_next      = ST_RELEASE;
                    end else if (r_count == c_TIMEOUT) begin
                        w_err             = 1'b1;
                        w_last_grant_next = r_grant[1];
                        w_state_next      = ST_RELEASE;
                    end else begin
                        w_count_next = r_count + 8'd1;
                    end
                end
            end

            ST_RELEASE: begin
                // STB stays low so a single-cycle-ack slave is not re-triggered.
                out_s_cyc = w_g_cyc ? w_slave_onehot : '0;
                if (!w_g_stb || !w_g_cyc) begin
                    w_grant_next = 2'b00;
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_grant_next = 2'b00;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign out_m0_ack = w_ack & r_grant[0];
    assign out_m0_err = w_err & r_grant[0];
    assign out_m0_dat = r_grant[0] ? w_rdat : 32'h0;
    assign out_m1_ack = w_ack & r_grant[1];
    assign out_m1_err = w_err & r_grant[1];
    assign out_m1_dat = r_grant[1] ? w_rdat : 32'h0;
    assign out_grant  = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_wishbone_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wishbone_reg_arbiter
// Description : Self-checking bench for wishbone_reg_arbiter: directed
//               scenarios plus randomized rounds checked against a
//               transaction-level timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wishbone_reg_arbiter;

    localparam int NS = 4;
    localparam int AW = 6;
    localparam int TO = 15;

    logic            in_clock = 1'b0;
    logic            in_reset;
    logic            in_m0_cyc, in_m0_stb, in_m0_we;
    logic [3:0]      in_m0_sel;
    logic [AW-1:0]   in_m0_adr;
    logic [31:0]     in_m0_dat;
    logic            in_m1_cyc, in_m1_stb, in_m1_we;
    logic [3:0]      in_m1_sel;
    logic [AW-1:0]   in_m1_adr;
    logic [31:0]     in_m1_dat;
    logic            out_m0_ack, out_m0_err, out_m1_ack, out_m1_err;
    logic [31:0]     out_m0_dat, out_m1_dat;
    logic [NS-1:0]   out_s_cyc, out_s_stb;
    logic            out_s_we;
    logic [3:0]      out_s_sel;
    logic [31:0]     out_s_dat;
    logic [NS-1:0]   in_s_ack;
    logic [32*NS-1:0] in_s_dat;
    logic [1:0]      out_grant;

    // Per-master transaction description and model state.
    bit              req [2];
    bit              t_we [2];
    logic [AW-1:0]   t_adr [2];
    logic [3:0]      t_sel [2];
    logic [31:0]     t_dat [2];
    logic [31:0]     t_rdat [2];
    int              t_lat [2];
    int              model_last;
    int              checks, errors;

    wishbone_reg_arbiter #(
        .NUM_SLAVES     (NS),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .in_clock   (in_clock),
        .in_reset   (in_reset),
        .in_m0_cyc  (in_m0_cyc),
        .in_m0_stb  (in_m0_stb),
        .in_m0_we   (in_m0_we),
        .in_m0_sel  (in_m0_sel),
        .in_m0_adr  (in_m0_adr),
        .in_m0_dat  (in_m0_dat),
        .out_m0_ack (out_m0_ack),
        .out_m0_err (out_m0_err),
        .out_m0_dat (out_m0_dat),
        .in_m1_cyc  (in_m1_cyc),
        .in_m1_stb  (in_m1_stb),
        .in_m1_we   (in_m1_we),
        .in_m1_sel  (in_m1_sel),
        .in_m1_adr  (in_m1_adr),
        .in_m1_dat  (in_m1_dat),
        .out_m1_ack (out_m1_ack),
        .out_m1_err (out_m1_err),
        .out_m1_dat (out_m1_dat),
        .out_s_cyc  (out_s_cyc),
        .out_s_stb  (out_s_stb),
        .out_s_we   (out_s_we),
        .out_s_sel  (out_s_sel),
        .out_s_dat  (out_s_dat),
        .in_s_ack   (in_s_ack),
        .in_s_dat   (in_s_dat),
        .out_grant  (out_grant)
    );

    always #5 in_clock = ~in_clock;

    function automatic logic [67:0] mbus();
        return {out_m0_ack, out_m0_err, out_m0_dat, out_m1_ack, out_m1_err, out_m1_dat};
    endfunction

    function automatic logic [114:0] allout();
        return {out_grant, out_s_cyc, out_s_stb, out_s_we, out_s_sel, out_s_dat, mbus()};
    endfunction

    task automatic drive();
        in_m0_cyc = req[0]; in_m0_stb = req[0]; in_m0_we = t_we[0];
        in_m0_sel = t_sel[0]; in_m0_adr = t_adr[0]; in_m0_dat = t_dat[0];
        in_m1_cyc = req[1]; in_m1_stb = req[1]; in_m1_we = t_we[1];
        in_m1_sel = t_sel[1]; in_m1_adr = t_adr[1]; in_m1_dat = t_dat[1];
    endtask

    task automatic noise_dat();
        for (int k = 0; k < NS; k++) in_s_dat[32*k +: 32] = $urandom;
    endtask

    task automatic set_txn(input int m, input bit we, input logic [AW-1:0] adr,
                           input logic [3:0] sel, input logic [31:0] dat,
                           input logic [31:0] rdat, input int lat);
        t_we[m] = we; t_adr[m] = adr; t_sel[m] = sel;
        t_dat[m] = dat; t_rdat[m] = rdat; t_lat[m] = lat;
    endtask

    task automatic rand_txn(input int m);
        logic [3:0] idx;
        idx = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(0, NS-1)) : 4'($urandom_range(0, 15));
        set_txn(m, 1'($urandom_range(0, 1)), {idx, 2'($urandom_range(0, 3))},
                4'($urandom), $urandom, $urandom, $urandom_range(0, TO+3));
    endtask

    // One full transaction of master g from its arbitration cycle through
    // release; entered at posedge+1 with the DUT idle and g about to win.
    task automatic serve(input int g, output int resp_j);
        int          idx;
        bit          hit, done, e_ack, e_err;
        logic [3:0]  oh;
        logic [1:0]  gv;
        logic [31:0] e_dat;
        logic [67:0] e_mb, a_mb;
        idx    = int'(t_adr[g] >> 2);
        hit    = (idx < NS);
        oh     = hit ? 4'(1 << idx) : 4'b0;
        gv     = 2'(1 << g);
        resp_j = -1;
        in_s_ack = 4'($urandom);
        noise_dat();
        @(negedge in_clock);
        checks++;
        if (allout() !== '0) begin
            errors++;
            $display("FAIL arb_cycle_idle g=%0d got=%h exp=0", g, allout());
        end
        @(posedge in_clock); #1;
        done = 0;
        for (int j = 0; j <= TO && !done; j++) begin
            e_ack = hit && (j == t_lat[g]);
            e_err = hit ? (!e_ack && j == TO) : (j == 0);
            in_s_ack = (4'($urandom) & ~oh) | (e_ack ? oh : 4'b0);
            noise_dat();
            if (hit) in_s_dat[32*idx +: 32] = t_rdat[g];
            e_dat = (e_ack && !t_we[g]) ? t_rdat[g] : 32'h0;
            e_mb  = (g == 0) ? {e_ack, e_err, e_dat, 34'h0} : {34'h0, e_ack, e_err, e_dat};
            @(negedge in_clock);
            a_mb = mbus();
            checks++;
            if ({out_grant, out_s_cyc, out_s_stb} !== {gv, oh, oh}) begin
                errors++;
                $display("FAIL busy_bus g=%0d j=%0d got=%b exp=%b", g, j,
                         {out_grant, out_s_cyc, out_s_stb}, {gv, oh, oh});
            end
            checks++;
            if (a_mb !== e_mb) begin
                errors++;
                $display("FAIL busy_master g=%0d j=%0d got=%h exp=%h", g, j, a_mb, e_mb);
            end
            if (hit) begin
                checks++;
                if ({out_s_we, out_s_sel, out_s_dat} !== {t_we[g], t_sel[g], t_dat[g]}) begin
                    errors++;
                    $display("FAIL busy_slave_mux g=%0d got=%h exp=%h", g,
                             {out_s_we, out_s_sel, out_s_dat}, {t_we[g], t_sel[g], t_dat[g]});
                end
            end
            if (resp_j < 0 && ((g == 0) ? (out_m0_ack | out_m0_err) : (out_m1_ack | out_m1_err)))
                resp_j = j;
            done = e_ack || e_err;
            @(posedge in_clock); #1;
        end
        // Release with the request still held: CYC kept, STB low, no response.
        in_s_ack = 4'($urandom);
        @(negedge in_clock);
        checks++;
        if ({out_grant, out_s_cyc, out_s_stb, mbus()} !== {gv, oh, 4'b0, 68'h0}) begin
            errors++;
            $display("FAIL release_hold g=%0d got=%h exp=%h", g,
                     {out_grant, out_s_cyc, out_s_stb, mbus()}, {gv, oh, 4'b0, 68'h0});
        end
        @(posedge in_clock); #1;
        req[g] = 0;
        drive();
        @(negedge in_clock);
        checks++;
        if ({out_grant, out_s_cyc, out_s_stb, mbus()} !== {gv, 4'b0, 4'b0, 68'h0}) begin
            errors++;
            $display("FAIL release_drop g=%0d got=%h exp=%h", g,
                     {out_grant, out_s_cyc, out_s_stb, mbus()}, {gv, 4'b0, 4'b0, 68'h0});
        end
        model_last = g;
        @(posedge in_clock); #1;
    endtask

    task automatic test_reset();
        in_reset = 1'b1;
        set_txn(0, 1'b1, 6'h04, 4'hF, 32'h1111_1111, 32'h0, 0);
        set_txn(1, 1'b0, 6'h08, 4'hF, 32'h2222_2222, 32'h0, 0);
        req[0] = 1; req[1] = 1;
        drive();
        repeat (3) begin
            in_s_ack = 4'($urandom);
            @(negedge in_clock);
            checks++;
            if (allout() !== '0) begin
                errors++;
                $display("FAIL reset_outputs got=%h exp=0", allout());
            end
        end
        req[0] = 0; req[1] = 0;
        drive();
        @(posedge in_clock); #1;
        in_reset = 1'b0;
        model_last = 1;
    endtask

    task automatic test_tie();
        int rj;
        set_txn(0, 1'b1, 6'h00, 4'hF, 32'hCAFE_0000, 32'h0, 1);
        set_txn(1, 1'b0, 6'h0C, 4'hF, 32'h0, 32'hBEEF_0003, 0);
        req[0] = 1; req[1] = 1;
        drive();
        serve(0, rj);
        serve(1, rj);
        set_txn(0, 1'b0, 6'h08, 4'h3, 32'h0, 32'h0BAD_F00D, 2);
        set_txn(1, 1'b1, 6'h04, 4'hC, 32'h7777_8888, 32'h0, 0);
        req[0] = 1; req[1] = 1;
        drive();
        serve(0, rj);
        serve(1, rj);
    endtask

    task automatic test_write();
        int rj;
        set_txn(0, 1'b1, 6'h04, 4'b0011, 32'hAABB_CCDD, 32'h0, 3);
        req[0] = 1; req[1] = 0;
        drive();
        serve(0, rj);
        checks++;
        if (rj !== 3) begin
            errors++;
            $display("FAIL write_ack_cycle got=%0d exp=3", rj);
        end
    endtask

    task automatic test_read_m1();
        int rj;
        set_txn(1, 1'b0, 6'h08, 4'hF, 32'h0, 32'h1234_5678, 2);
        req[0] = 0; req[1] = 1;
        drive();
        serve(1, rj);
        checks++;
        if (rj !== 2) begin
            errors++;
            $display("FAIL read_ack_cycle got=%0d exp=2", rj);
        end
    endtask

    task automatic test_miss();
        int rj;
        set_txn(0, 1'b0, 6'h3C, 4'hF, 32'h0, 32'h0, 0);
        req[0] = 1; req[1] = 0;
        drive();
        serve(0, rj);
        checks++;
        if (rj !== 0) begin
            errors++;
            $display("FAIL miss_err_cycle got=%0d exp=0", rj);
        end
    endtask

    task automatic test_timeout();
        int rj;
        set_txn(0, 1'b0, 6'h04, 4'hF, 32'h0, 32'h0, 1000);
        req[0] = 1; req[1] = 0;
        drive();
        serve(0, rj);
        checks++;
        if (rj !== TO) begin
            errors++;
            $display("FAIL timeout_err_cycle got=%0d exp=%0d", rj, TO);
        end
    endtask

    task automatic test_abort();
        set_txn(0, 1'b1, 6'h04, 4'hF, 32'h3333_4444, 32'h0, 1000);
        req[0] = 1; req[1] = 0;
        drive();
        in_s_ack = 4'b0;
        @(posedge in_clock); #1;
        @(negedge in_clock);
        checks++;
        if ({out_grant, out_s_cyc, out_s_stb} !== 10'b01_0010_0010) begin
            errors++;
            $display("FAIL abort_busy got=%b exp=0100100010", {out_grant, out_s_cyc, out_s_stb});
        end
        @(posedge in_clock); #1;
        req[0] = 0;
        drive();
        @(negedge in_clock);
        checks++;
        if ({out_grant, out_s_cyc, out_s_stb, mbus()} !== {2'b01, 8'h0, 68'h0}) begin
            errors++;
            $display("FAIL abort_drop got=%h exp=%h", {out_grant, out_s_cyc, out_s_stb, mbus()},
                     {2'b01, 8'h0, 68'h0});
        end
        @(posedge in_clock); #1;
        @(negedge in_clock);
        checks++;
        if (allout() !== '0) begin
            errors++;
            $display("FAIL abort_idle got=%h exp=0", allout());
        end
        model_last = 0;
        @(posedge in_clock); #1;
    endtask

    task automatic test_reset_mid();
        int rj;
        set_txn(0, 1'b1, 6'h04, 4'hF, 32'h55AA_55AA, 32'h0, 1000);
        req[0] = 1; req[1] = 0;
        drive();
        in_s_ack = 4'b0;
        repeat (3) begin
            @(posedge in_clock); #1;
        end
        @(negedge in_clock);
        checks++;
        if (out_s_stb !== 4'b0010) begin
            errors++;
            $display("FAIL reset_mid_busy got=%b exp=0010", out_s_stb);
        end
        @(posedge in_clock); #1;
        in_reset = 1'b1;
        #1;
        checks++;
        if (allout() !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs got=%h exp=0", allout());
        end
        req[0] = 0;
        drive();
        @(posedge in_clock); #1;
        in_reset = 1'b0;
        model_last = 1;
        set_txn(1, 1'b0, 6'h0C, 4'hF, 32'h0, 32'hFACE_B00C, 1);
        req[1] = 1;
        drive();
        serve(1, rj);
        checks++;
        if (rj !== 1) begin
            errors++;
            $display("FAIL reset_mid_fresh got=%0d exp=1", rj);
        end
    endtask

    task automatic test_random(input int n);
        int r, first, rj;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(1, 3);
            for (int m = 0; m < 2; m++) begin
                req[m] = r[m];
                if (r[m]) rand_txn(m);
            end
            drive();
            first = (r == 3) ? ((model_last == 1) ? 0 : 1) : ((r == 2) ? 1 : 0);
            serve(first, rj);
            if (r == 3) serve(1 - first, rj);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        in_reset = 1'b1;
        req[0]   = 0;
        req[1]   = 0;
        for (int m = 0; m < 2; m++) set_txn(m, 1'b0, '0, 4'h0, 32'h0, 32'h0, 0);
        drive();
        in_s_ack = '0;
        in_s_dat = '0;
        model_last = 1;

        test_reset();
        test_tie();
        test_write();
        test_read_m1();
        test_miss();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_random(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
